// File: rtl/debounce_scheduler.sv
// debounce_scheduler
//   Debounces a bank of WIDTH raw button/switch inputs with a single shared
//   hold counter. A round-robin scheduler grants the counter to one input whose
//   registered raw value differs from its debounced value. The new value is
//   committed once that input has stayed stable for N cycles, and a one-cycle
//   press or release pulse is emitted at the same time.
//
// Ports
//   clk            system clock, rising edge
//   sys_rst        synchronous active-high reset
//   org            raw (bouncing, asynchronous) inputs
//   debounced      committed stable values
//   press_pulse    one-cycle pulse per bit on a 0->1 commit
//   release_pulse  one-cycle pulse per bit on a 1->0 commit
//   busy           high while the counter is granted to an input
//   grant_idx      index owning the counter, 0 when idle
module debounce_scheduler #(
    parameter  int N     = 20,
    parameter  int WIDTH = 4,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] org,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic             busy,
    output logic [IW-1:0]    grant_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] org_reg;
    logic [WIDTH-1:0] pending;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    rr_last_q, rr_last_d;
    logic [IW-1:0]    pick;
    logic             v_q, v_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] debounced_d;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] release_d;

    // First pending bit strictly after 'last', wrapping modulo WIDTH. The last
    // granted index is therefore always the lowest priority.
    function automatic logic [IW-1:0] rr_pick(input logic [WIDTH-1:0] p,
                                              input logic [IW-1:0]    last);
        logic [IW-1:0] r;
        logic          hit;
        int            j;
        r   = '0;
        hit = 1'b0;
        for (int off = 1; off <= WIDTH; off++) begin
            j = (int'(last) + off) % WIDTH;
            if (!hit && p[IW'(j)]) begin
                hit = 1'b1;
                r   = IW'(j);
            end
        end
        return r;
    endfunction

    assign pending   = org_reg ^ debounced;
    assign pick      = rr_pick(pending, rr_last_q);
    assign busy      = (state_q == HOLD);
    assign grant_idx = (state_q == HOLD) ? idx_q : '0;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        v_d         = v_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        debounced_d = debounced;
        press_d     = '0;
        release_d   = '0;
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    idx_d     = pick;
                    v_d       = org_reg[pick];
                    cnt_d     = '0;
                    rr_last_d = pick;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (org_reg[idx_q] != v_q) begin
                    // Input moved during the hold window: drop the grant.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CW'(N - 1)) begin
                    debounced_d[idx_q] = v_q;
                    press_d[idx_q]     = v_q;
                    release_d[idx_q]   = ~v_q;
                    cnt_d              = '0;
                    state_d            = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            org_reg       <= '0;
            idx_q         <= '0;
            rr_last_q     <= IW'(WIDTH - 1);
            v_q           <= 1'b0;
            cnt_q         <= '0;
            debounced     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            state_q       <= state_d;
            org_reg       <= org;
            idx_q         <= idx_d;
            rr_last_q     <= rr_last_d;
            v_q           <= v_d;
            cnt_q         <= cnt_d;
            debounced     <= debounced_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler
//   Directed bench for debounce_scheduler with N=4, WIDTH=4. Inputs are driven
//   1 time unit after a rising edge and outputs are sampled at the same point.
//   Edge k in each scenario is the k-th rising edge after org is driven.
module tb_debounce_scheduler;

    localparam int N     = 4;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [WIDTH-1:0] org = '0;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic             busy;
    logic [1:0]       grant_idx;

    int checks = 0;
    int failures = 0;

    debounce_scheduler #(.N(N), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .org          (org),
        .debounced    (debounced),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .busy         (busy),
        .grant_idx    (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        org     = '0;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        org     = 4'b1111;
        sys_rst = 1'b1;
        tick();
        tick();
        checks++;
        if (debounced !== 4'b0000) begin
            failures++;
            $display("FAIL reset_debounced got=%b want=0000", debounced);
        end
        checks++;
        if (press_pulse !== 4'b0000 || release_pulse !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses got=%b/%b want=0000/0000", press_pulse, release_pulse);
        end
        checks++;
        if (busy !== 1'b0 || grant_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_busy got=%b/%0d want=0/0", busy, grant_idx);
        end
        do_reset();
    endtask

    task automatic test_single_press();
        logic [3:0] e_deb, e_prs;
        logic       e_busy;
        do_reset();
        org = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_deb  = (k >= 6) ? 4'b0001 : 4'b0000;
            e_prs  = (k == 6) ? 4'b0001 : 4'b0000;
            e_busy = (k >= 2 && k <= 5);
            checks++;
            if (debounced !== e_deb) begin
                failures++;
                $display("FAIL single_deb edge=%0d got=%b want=%b", k, debounced, e_deb);
            end
            checks++;
            if (press_pulse !== e_prs || release_pulse !== 4'b0000) begin
                failures++;
                $display("FAIL single_pulse edge=%0d got=%b/%b want=%b/0000", k, press_pulse, release_pulse, e_prs);
            end
            checks++;
            if (busy !== e_busy || grant_idx !== 2'd0) begin
                failures++;
                $display("FAIL single_busy edge=%0d got=%b/%0d want=%b/0", k, busy, grant_idx, e_busy);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        org = 4'b0001;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL bounce_grant got=%b want=1", busy);
        end
        org = 4'b0000;
        for (int k = 3; k <= 10; k++) begin
            tick();
            checks++;
            if (busy !== (k == 3)) begin
                failures++;
                $display("FAIL bounce_busy edge=%0d got=%b want=%b", k, busy, (k == 3));
            end
            checks++;
            if (debounced !== 4'b0000 || press_pulse !== 4'b0000 || release_pulse !== 4'b0000) begin
                failures++;
                $display("FAIL bounce_out edge=%0d got=%b/%b/%b want=0000/0000/0000", k, debounced, press_pulse, release_pulse);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_deb, e_prs;
        logic       e_busy;
        logic [1:0] e_gi;
        do_reset();
        org = 4'b0110;
        for (int k = 1; k <= 13; k++) begin
            tick();
            e_deb  = {1'b0, (k >= 11), (k >= 6), 1'b0};
            e_prs  = {1'b0, (k == 11), (k == 6), 1'b0};
            e_busy = (k >= 2 && k <= 5) || (k >= 7 && k <= 10);
            e_gi   = (k >= 2 && k <= 5) ? 2'd1 : ((k >= 7 && k <= 10) ? 2'd2 : 2'd0);
            checks++;
            if (debounced !== e_deb) begin
                failures++;
                $display("FAIL b2b_deb edge=%0d got=%b want=%b", k, debounced, e_deb);
            end
            checks++;
            if (press_pulse !== e_prs || release_pulse !== 4'b0000) begin
                failures++;
                $display("FAIL b2b_pulse edge=%0d got=%b/%b want=%b/0000", k, press_pulse, release_pulse, e_prs);
            end
            checks++;
            if (busy !== e_busy || grant_idx !== e_gi) begin
                failures++;
                $display("FAIL b2b_grant edge=%0d got=%b/%0d want=%b/%0d", k, busy, grant_idx, e_busy, e_gi);
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        org = 4'b1000;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || grant_idx !== 2'd3) begin
            failures++;
            $display("FAIL fair_first got=%b/%0d want=1/3", busy, grant_idx);
        end
        org = 4'b0001;
        tick();
        org = 4'b1001;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL fair_abort got=%b want=0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || grant_idx !== 2'd0) begin
            failures++;
            $display("FAIL fair_next got=%b/%0d want=1/0", busy, grant_idx);
        end
        repeat (4) tick();
        checks++;
        if (debounced !== 4'b0001 || press_pulse !== 4'b0001) begin
            failures++;
            $display("FAIL fair_commit0 got=%b/%b want=0001/0001", debounced, press_pulse);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || grant_idx !== 2'd3) begin
            failures++;
            $display("FAIL fair_regrant got=%b/%0d want=1/3", busy, grant_idx);
        end
        repeat (4) tick();
        checks++;
        if (debounced !== 4'b1001 || press_pulse !== 4'b1000) begin
            failures++;
            $display("FAIL fair_commit3 got=%b/%b want=1001/1000", debounced, press_pulse);
        end
    endtask

    task automatic test_release();
        logic [3:0] e_deb, e_rel;
        do_reset();
        org = 4'b0100;
        repeat (7) tick();
        checks++;
        if (debounced !== 4'b0100) begin
            failures++;
            $display("FAIL rel_setup got=%b want=0100", debounced);
        end
        org = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_deb = (k >= 6) ? 4'b0000 : 4'b0100;
            e_rel = (k == 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (debounced !== e_deb) begin
                failures++;
                $display("FAIL rel_deb edge=%0d got=%b want=%b", k, debounced, e_deb);
            end
            checks++;
            if (release_pulse !== e_rel || press_pulse !== 4'b0000) begin
                failures++;
                $display("FAIL rel_pulse edge=%0d got=%b/%b want=%b/0000", k, release_pulse, press_pulse, e_rel);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        do_reset();
        org = 4'b0001;
        tick();
        tick();
        sys_rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || grant_idx !== 2'd0 || debounced !== 4'b0000 ||
            press_pulse !== 4'b0000 || release_pulse !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_clear got=%b/%0d/%b/%b/%b want=0/0/0000/0000/0000",
                     busy, grant_idx, debounced, press_pulse, release_pulse);
        end
        sys_rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            e = (k >= 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (debounced !== e) begin
                failures++;
                $display("FAIL rstmid_deb edge=%0d got=%b want=%b", k, debounced, e);
            end
            checks++;
            if (press_pulse !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL rstmid_pulse edge=%0d got=%b", k, press_pulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_back_to_back();
        test_fairness();
        test_release();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
